// File: rtl/imem_ctrl_pkg.sv
// Shared types and constants for the instruction-memory controller.
package imem_ctrl_pkg;

  localparam int                WORD_W            = 32;
  localparam logic [WORD_W-1:0] DEFAULT_HALT_WORD = 32'h0000_0000;
  localparam logic [WORD_W-1:0] PC_STEP           = 32'd4;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_e;

endpackage

// File: rtl/imem_ctrl_if.sv
// Loader, memory and fetch signals of the instruction-memory controller.
interface imem_ctrl_if #(
  parameter int AW = 6
);
  import imem_ctrl_pkg::*;

  logic              ld_valid;
  logic              ld_ready;
  logic [WORD_W-1:0] ld_data;
  logic              ld_last;

  logic              mem_we;
  logic [AW-1:0]     mem_addr;
  logic [WORD_W-1:0] mem_wdata;
  logic [WORD_W-1:0] mem_rdata;

  logic              stall;
  logic              redirect;
  logic [WORD_W-1:0] redirect_pc;
  logic [WORD_W-1:0] pc;
  logic [WORD_W-1:0] instr;
  logic              instr_valid;
  logic              halted;
  logic              fault;

  modport master (
    input  ld_valid, ld_data, ld_last, mem_rdata, stall, redirect, redirect_pc,
    output ld_ready, mem_we, mem_addr, mem_wdata, pc, instr, instr_valid, halted, fault
  );

  modport slave (
    output ld_valid, ld_data, ld_last, mem_rdata, stall, redirect, redirect_pc,
    input  ld_ready, mem_we, mem_addr, mem_wdata, pc, instr, instr_valid, halted, fault
  );

endinterface

// File: rtl/imem_ctrl.sv
// Instruction-memory sequencer: loads a program image, then fetches until a
// terminator word or an illegal PC stops it.
module imem_ctrl
  import imem_ctrl_pkg::*;
#(
  parameter int                DEPTH     = 64,
  parameter int                AW        = 6,
  parameter logic [WORD_W-1:0] RESET_PC  = 32'h0000_0000,
  parameter logic [WORD_W-1:0] HALT_WORD = DEFAULT_HALT_WORD,
  parameter bit                LOAD_EN   = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  imem_ctrl_if.master bus
);

  localparam logic [WORD_W-1:0] PC_LIMIT    = WORD_W'(DEPTH * 4);
  localparam logic [AW-1:0]     LAST_ADDR   = AW'(DEPTH - 1);
  localparam state_e            RESET_STATE = LOAD_EN ? LOAD : RUN;

  state_e            state_q, state_d;
  logic [WORD_W-1:0] pc_q, pc_d;
  logic [AW-1:0]     ld_addr_q, ld_addr_d;
  logic              fault_q, fault_d;
  logic              pc_in_range;

  assign pc_in_range = (pc_q < PC_LIMIT);

  // NOTE: registers use non-blocking assignments so every flop samples the
  // pre-edge value of its neighbours; reset is synchronous, sampled on clk.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= RESET_STATE;
      pc_q      <= RESET_PC;
      ld_addr_q <= '0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ld_addr_q <= ld_addr_d;
      fault_q   <= fault_d;
    end
  end

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d         = state_q;
    pc_d            = pc_q;
    ld_addr_d       = ld_addr_q;
    fault_d         = fault_q;
    bus.ld_ready    = 1'b0;
    bus.mem_we      = 1'b0;
    bus.mem_addr    = pc_q[AW+1:2];
    bus.mem_wdata   = bus.ld_data;
    bus.instr       = bus.mem_rdata;
    bus.instr_valid = 1'b0;
    bus.halted      = 1'b0;
    bus.fault       = fault_q;
    bus.pc          = pc_q;

    case (state_q)
      LOAD: begin
        bus.ld_ready = 1'b1;
        bus.mem_addr = ld_addr_q;
        bus.mem_we   = bus.ld_valid;
        if (bus.ld_valid) begin
          // The last slot ends the load even without ld_last; no wrap-around.
          if (bus.ld_last || (ld_addr_q == LAST_ADDR)) begin
            state_d = RUN;
            pc_d    = RESET_PC;
          end else begin
            ld_addr_d = ld_addr_q + AW'(1);
          end
        end
      end

      RUN: begin
        bus.instr_valid = pc_in_range;
        if (!pc_in_range) begin
          state_d = HALT;
          fault_d = 1'b1;
        end else if (bus.redirect) begin
          if (bus.redirect_pc[1:0] != 2'b00) begin
            state_d = HALT;
            fault_d = 1'b1;
          end else begin
            pc_d = bus.redirect_pc;
          end
        end else if (!bus.stall) begin
          // Terminator only counts when the core is neither stalling nor redirecting.
          if (bus.mem_rdata == HALT_WORD) begin
            state_d = HALT;
          end else begin
            pc_d = pc_q + PC_STEP;
          end
        end
      end

      HALT: begin
        bus.halted = 1'b1;
      end

      default: begin
        state_d = RESET_STATE;
      end
    endcase
  end

endmodule
